// File: rtl/simd_pkg.sv
// simd_pkg: shared definitions for simd_processing_block.
//   opcode_e   - instruction opcodes; encodings 4..15 are treated as NOP
//   state_e    - top-level run/drain/halt sequencing
//   *_LSB/*_W  - bit positions of the fields in the 32-bit instruction word
package simd_pkg;

    typedef enum logic [3:0] {
        OP_NOP     = 4'd0,
        OP_ALU     = 4'd1,
        OP_HALT    = 4'd2,
        OP_SETMASK = 4'd3
    } opcode_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam int OPC_LSB  = 28;
    localparam int OPC_W    = 4;
    localparam int CTRL_LSB = 24;
    localparam int CTRL_W   = 4;
    localparam int DST_LSB  = 16;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_LSB = 0;

endpackage

// File: rtl/alu_bf16.sv
// alu_bf16: one bf16 lane, result delayed by LAT registers.
//   a, b  - bf16 operands
//   ctrl  - 0 add, 1 subtract (a - b), other codes pass a through
//   y     - result, LAT cycles after the operands
// Arithmetic truncates toward zero, flushes subnormals to zero and
// saturates exponent overflow to infinity.
module alu_bf16 #(
    parameter int LAT = 1
) (
    input  logic        clock,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  ctrl,
    output logic [15:0] y
);

    // Normalises a 12-bit magnitude whose leading one belongs at bit 10.
    function automatic logic [15:0] bf16_pack(input logic sign,
                                              input logic signed [9:0] exp_in,
                                              input logic [11:0] sum);
        logic [11:0]       s;
        logic signed [9:0] e;
        s = sum;
        e = exp_in;
        if (s == 12'd0)
            return 16'h0000;
        if (s[11]) begin
            s = s >> 1;
            e = e + 10'sd1;
        end else begin
            for (int i = 0; i < 11; i++)
                if (!s[10]) begin
                    s = s << 1;
                    e = e - 10'sd1;
                end
        end
        if (e >= 10'sd255)
            return {sign, 8'hFF, 7'h00};
        if (e <= 10'sd0)
            return {sign, 15'h0000};
        return {sign, e[7:0], s[9:3]};
    endfunction

    // Three guard bits keep the borrow exact when magnitudes nearly cancel.
    function automatic logic [15:0] bf16_add(input logic [15:0] p, input logic [15:0] q);
        logic [15:0] x, z;
        logic [10:0] mx, mz;
        logic [7:0]  d;
        logic [11:0] s;
        if (p[14:0] >= q[14:0]) begin
            x = p; z = q;
        end else begin
            x = q; z = p;
        end
        mx = (x[14:7] != 8'd0) ? {1'b1, x[6:0], 3'b000} : 11'd0;
        mz = (z[14:7] != 8'd0) ? {1'b1, z[6:0], 3'b000} : 11'd0;
        d  = x[14:7] - z[14:7];
        mz = (d > 8'd10) ? 11'd0 : (mz >> d);
        s  = (x[15] == z[15]) ? ({1'b0, mx} + {1'b0, mz}) : ({1'b0, mx} - {1'b0, mz});
        return bf16_pack(x[15], $signed({2'b00, x[14:7]}), s);
    endfunction

    logic [15:0] y_c;
    logic [15:0] y_p [LAT];

    always_comb begin
        case (ctrl)
            4'd0:    y_c = bf16_add(a, b);
            4'd1:    y_c = bf16_add(a, b ^ 16'h8000);
            default: y_c = a;
        endcase
    end

    always_ff @(posedge clock) begin
        y_p[0] <= y_c;
        for (int i = 1; i < LAT; i++)
            y_p[i] <= y_p[i-1];
    end

    assign y = y_p[LAT-1];

endmodule

// File: rtl/lane_reg_file.sv
// lane_reg_file: 2^ADDR_W vector registers of LANES*BITS bits.
//   rd1/rd2     - asynchronous operand read ports (addr in, data out)
//   dbg         - asynchronous debug read port plus full-width debug write
//   wb          - writeback port with a per-lane enable (LANES bits)
// When debug and writeback hit the same register in one cycle, writeback
// wins on its enabled lanes and debug data lands on the remaining lanes.
module lane_reg_file #(
    parameter int LANES  = 32,
    parameter int BITS   = 16,
    parameter int ADDR_W = 8
) (
    input  logic                    clock,
    input  logic [ADDR_W-1:0]       rd1_addr,
    output logic [LANES*BITS-1:0]   rd1_data,
    input  logic [ADDR_W-1:0]       rd2_addr,
    output logic [LANES*BITS-1:0]   rd2_data,
    input  logic [ADDR_W-1:0]       dbg_addr,
    output logic [LANES*BITS-1:0]   dbg_rdata,
    input  logic                    dbg_we,
    input  logic [LANES*BITS-1:0]   dbg_wdata,
    input  logic                    wb_we,
    input  logic [ADDR_W-1:0]       wb_addr,
    input  logic [LANES-1:0]        wb_lane_en,
    input  logic [LANES*BITS-1:0]   wb_data
);

    logic [LANES*BITS-1:0] mem [2**ADDR_W];

    assign rd1_data  = mem[rd1_addr];
    assign rd2_data  = mem[rd2_addr];
    assign dbg_rdata = mem[dbg_addr];

    // The lane writes follow the debug write so they override it lane by lane.
    always_ff @(posedge clock) begin
        if (dbg_we)
            mem[dbg_addr] <= dbg_wdata;
        if (wb_we)
            for (int i = 0; i < LANES; i++)
                if (wb_lane_en[i])
                    mem[wb_addr][i*BITS +: BITS] <= wb_data[i*BITS +: BITS];
    end

endmodule

// File: rtl/simd_processing_block.sv
// simd_processing_block: LANES-wide bf16 vector unit fed by a valid/ready
// instruction stream.
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   instr_valid/ready/instr - instruction handshake; ready depends on instr
//   pc                      - accepted-instruction count (wraps)
//   busy                    - an instruction sits in issue, EX or WB
//   halted                  - HALT has retired and the pipeline is empty
//   dbg_we/addr/wdata/rdata - debug register access (combinational read)
// Pipeline: accept -> issue (register read, mask sample) -> ALU_LAT EX
// stages, the last of which is the writeback cycle.
module simd_processing_block import simd_pkg::*; #(
    parameter int LANES   = 32,
    parameter int BITS    = 16,
    parameter int ADDR_W  = 8,
    parameter int PC_W    = 16,
    parameter int ALU_LAT = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instr,
    output logic [PC_W-1:0]       pc,
    output logic                  busy,
    output logic                  halted,
    input  logic                  dbg_we,
    input  logic [ADDR_W-1:0]     dbg_addr,
    input  logic [LANES*BITS-1:0] dbg_wdata,
    output logic [LANES*BITS-1:0] dbg_rdata
);

    localparam int DW = LANES*BITS;

    opcode_e             in_op;
    logic [3:0]          in_ctrl;
    logic [ADDR_W-1:0]   in_dst, in_src1, in_src2;
    logic                uses1, uses2, hazard, fire, ex_busy, issue_alu, wb_we;

    state_e              state;
    logic [LANES-1:0]    mask, setmask_val;

    logic                vld_p0;
    opcode_e             op_p0;
    logic [3:0]          ctrl_p0;
    logic [ADDR_W-1:0]   dst_p0, src1_p0, src2_p0;

    logic [ALU_LAT-1:0]  vld_p1;
    logic [ADDR_W-1:0]   dst_p1  [ALU_LAT];
    logic [LANES-1:0]    mask_p1 [ALU_LAT];

    logic [DW-1:0]       rd1_data, rd2_data, alu_y;

    assign in_op   = opcode_e'(instr[OPC_LSB +: OPC_W]);
    assign in_ctrl = instr[CTRL_LSB +: CTRL_W];
    assign in_dst  = instr[DST_LSB  +: ADDR_W];
    assign in_src1 = instr[SRC1_LSB +: ADDR_W];
    assign in_src2 = instr[SRC2_LSB +: ADDR_W];

    assign uses1     = (in_op == OP_ALU) || (in_op == OP_SETMASK);
    assign uses2     = (in_op == OP_ALU);
    assign issue_alu = vld_p0 && (op_p0 == OP_ALU);

    // No forwarding: any source matching an in-flight ALU destination stalls.
    always_comb begin
        hazard = 1'b0;
        if (issue_alu && ((uses1 && in_src1 == dst_p0) || (uses2 && in_src2 == dst_p0)))
            hazard = 1'b1;
        for (int i = 0; i < ALU_LAT; i++)
            if (vld_p1[i] && ((uses1 && in_src1 == dst_p1[i]) || (uses2 && in_src2 == dst_p1[i])))
                hazard = 1'b1;
    end

    // Occupancy of EX stages that will still be in flight next cycle.
    always_comb begin
        ex_busy = 1'b0;
        for (int i = 0; i < ALU_LAT-1; i++)
            ex_busy = ex_busy | vld_p1[i];
    end

    always_comb begin
        for (int i = 0; i < LANES; i++)
            setmask_val[i] = (rd1_data[i*BITS +: BITS] != '0);
    end

    assign instr_ready = !reset && (state == ST_RUN) && !hazard;
    assign fire        = instr_valid && instr_ready;
    assign wb_we       = vld_p1[ALU_LAT-1] && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_RUN;
            pc     <= '0;
            busy   <= 1'b0;
            halted <= 1'b0;
            mask   <= '1;
            vld_p0 <= 1'b0;
            vld_p1 <= '0;
        end else begin
            vld_p0    <= fire;
            vld_p1[0] <= issue_alu;
            for (int i = 1; i < ALU_LAT; i++)
                vld_p1[i] <= vld_p1[i-1];
            if (fire)
                pc <= pc + 1'b1;
            busy <= fire || issue_alu || ex_busy;
            if (vld_p0 && op_p0 == OP_SETMASK)
                mask <= setmask_val;
            case (state)
                ST_RUN:
                    if (fire && in_op == OP_HALT)
                        state <= ST_DRAIN;
                ST_DRAIN:
                    if (!busy) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end
                default: ;
            endcase
        end
    end

    // accept -> issue (p0)
    always_ff @(posedge clock) begin
        if (fire) begin
            op_p0   <= in_op;
            ctrl_p0 <= in_ctrl;
            dst_p0  <= in_dst;
            src1_p0 <= in_src1;
            src2_p0 <= in_src2;
        end
    end

    // issue -> EX/WB (p1), aligned with the ALU output registers
    always_ff @(posedge clock) begin
        dst_p1[0]  <= dst_p0;
        mask_p1[0] <= mask;
        for (int i = 1; i < ALU_LAT; i++) begin
            dst_p1[i]  <= dst_p1[i-1];
            mask_p1[i] <= mask_p1[i-1];
        end
    end

    lane_reg_file #(.LANES(LANES), .BITS(BITS), .ADDR_W(ADDR_W)) u_rf (
        .clock      (clock),
        .rd1_addr   (src1_p0),
        .rd1_data   (rd1_data),
        .rd2_addr   (src2_p0),
        .rd2_data   (rd2_data),
        .dbg_addr   (dbg_addr),
        .dbg_rdata  (dbg_rdata),
        .dbg_we     (dbg_we),
        .dbg_wdata  (dbg_wdata),
        .wb_we      (wb_we),
        .wb_addr    (dst_p1[ALU_LAT-1]),
        .wb_lane_en (mask_p1[ALU_LAT-1]),
        .wb_data    (alu_y)
    );

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        alu_bf16 #(.LAT(ALU_LAT)) u_alu (
            .clock (clock),
            .a     (rd1_data[g*BITS +: BITS]),
            .b     (rd2_data[g*BITS +: BITS]),
            .ctrl  (ctrl_p0),
            .y     (alu_y[g*BITS +: BITS])
        );
    end

endmodule

// File: tb/tb_simd_processing_block.sv
// tb_simd_processing_block: directed checks of simd_processing_block with
// 8 lanes, a 4-bit pc and a two-cycle ALU. Inputs change 1 ns after each
// rising edge; outputs are sampled later in the same cycle.
module tb_simd_processing_block;

    localparam int LANES   = 8;
    localparam int BITS    = 16;
    localparam int ADDR_W  = 8;
    localparam int PC_W    = 4;
    localparam int ALU_LAT = 2;
    localparam int DW      = LANES*BITS;

    logic              clock = 1'b0;
    logic              reset;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [PC_W-1:0]   pc;
    logic              busy;
    logic              halted;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DW-1:0]     dbg_wdata;
    logic [DW-1:0]     dbg_rdata;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_v;

    always #5 clock = ~clock;

    simd_processing_block #(
        .LANES(LANES), .BITS(BITS), .ADDR_W(ADDR_W), .PC_W(PC_W), .ALU_LAT(ALU_LAT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_rdata   (dbg_rdata)
    );

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] ctrl,
                                       input logic [7:0] d, input logic [7:0] s1,
                                       input logic [7:0] s2);
        return {op, ctrl, d, s1, s2};
    endfunction

    function automatic logic [DW-1:0] rep(input logic [15:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++)
            r[i*16 +: 16] = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [7:0] a, input logic [DW-1:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, dbg_rdata, exp);
    endtask

    task automatic dload(input logic [7:0] a, input logic [DW-1:0] d);
        dbg_we    = 1'b1;
        dbg_addr  = a;
        dbg_wdata = d;
        tick();
        dbg_we    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = '0;
        dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

        // reset state
        #1 chk("ready_during_reset", instr_ready, 0);
        tick();
        chk("reset_pc", pc, 0);
        chk("reset_busy", busy, 0);
        chk("reset_halted", halted, 0);
        reset = 1'b0;
        #1 chk("ready_after_reset", instr_ready, 1);

        // register preload
        dload(8'd1, rep(16'h3F80));
        dload(8'd2, rep(16'h4000));
        for (int r = 3; r <= 7; r++)
            dload(8'(r), '0);
        dload(8'd8, rep(16'h1234));
        exp_v = '0;
        exp_v[0*16 +: 16] = 16'h0001;
        exp_v[5*16 +: 16] = 16'h1234;
        dload(8'd9, exp_v);
        chk_reg("preload_r1", 8'd1, rep(16'h3F80));

        // r3 = r1 + r2, visible at T+2+ALU_LAT
        instr = mk(4'd1, 4'd0, 8'd3, 8'd1, 8'd2); instr_valid = 1'b1;
        #1 chk("add_ready", instr_ready, 1);
        tick(); instr_valid = 1'b0;
        chk("add_pc", pc, 1);
        chk("add_busy", busy, 1);
        tick(); tick();
        chk_reg("add_r3_not_yet", 8'd3, '0);
        tick();
        chk_reg("add_r3", 8'd3, rep(16'h4040));
        chk("add_busy_idle", busy, 0);

        // dependent pair: r3 = r1 + r2 then r4 = r3 + r1
        instr = mk(4'd1, 4'd0, 8'd3, 8'd1, 8'd2); instr_valid = 1'b1;
        #1 chk("raw_first_ready", instr_ready, 1);
        tick();
        instr = mk(4'd1, 4'd0, 8'd4, 8'd3, 8'd1);
        #1 chk("raw_stall_issue", instr_ready, 0);
        tick();
        #1 chk("raw_stall_ex", instr_ready, 0);
        tick();
        #1 chk("raw_stall_wb", instr_ready, 0);
        tick();
        #1 chk("raw_release", instr_ready, 1);
        tick(); instr_valid = 1'b0;
        chk("raw_pc", pc, 3);
        tick(); tick();
        chk_reg("raw_r4_not_yet", 8'd4, '0);
        tick();
        chk_reg("raw_r4", 8'd4, rep(16'h4080));

        // SETMASK from r9 (lanes 0 and 5 nonzero), then masked ALU into r7
        instr = mk(4'd3, 4'd0, 8'd0, 8'd9, 8'd0); instr_valid = 1'b1;
        #1 chk("setmask_ready", instr_ready, 1);
        tick();
        instr = mk(4'd1, 4'd0, 8'd7, 8'd1, 8'd2);
        #1 chk("masked_alu_ready", instr_ready, 1);
        tick(); instr_valid = 1'b0;
        tick(); tick();
        chk_reg("masked_r7_not_yet", 8'd7, '0);
        tick();
        exp_v = '0;
        exp_v[0*16 +: 16] = 16'h4040;
        exp_v[5*16 +: 16] = 16'h4040;
        chk_reg("masked_r7", 8'd7, exp_v);

        // reset restores the mask; stream 2^PC_W+3 NOPs
        reset = 1'b1;
        #1 chk("ready_reset2", instr_ready, 0);
        tick(); reset = 1'b0;
        chk("reset2_pc", pc, 0);
        instr = '0; instr_valid = 1'b1;
        for (int i = 0; i < 19; i++) begin
            #1 chk("nop_ready", instr_ready, 1);
            tick();
        end
        instr_valid = 1'b0;
        chk("nop_pc_wrap", pc, 3);
        chk("nop_busy_last", busy, 1);
        tick();
        chk("nop_busy_low", busy, 0);

        // r7 = r1 + r1 with the restored all-ones mask
        instr = mk(4'd1, 4'd0, 8'd7, 8'd1, 8'd1); instr_valid = 1'b1;
        #1 chk("fullmask_ready", instr_ready, 1);
        tick(); instr_valid = 1'b0;
        tick(); tick(); tick();
        chk_reg("fullmask_r7", 8'd7, rep(16'h4000));

        // r5 = r2 - r1, HALT, then an ALU that must never be accepted
        instr = mk(4'd1, 4'd1, 8'd5, 8'd2, 8'd1); instr_valid = 1'b1;
        #1 chk("sub_ready", instr_ready, 1);
        tick();
        instr = mk(4'd2, 4'd0, 8'd0, 8'd0, 8'd0);
        #1 chk("halt_ready", instr_ready, 1);
        tick();
        instr = mk(4'd1, 4'd0, 8'd6, 8'd1, 8'd2);
        #1 chk("drain_ready", instr_ready, 0);
        chk("drain_halted", halted, 0);
        tick();
        #1 chk("drain_busy", busy, 1);
        tick();
        #1 chk("drain_busy_low", busy, 0);
        chk("drain_not_halted_yet", halted, 0);
        chk_reg("sub_r5", 8'd5, rep(16'h3F80));
        tick();
        chk("halted_set", halted, 1);
        chk("halted_pc", pc, 6);
        chk("halted_ready", instr_ready, 0);
        tick(); tick();
        chk("halted_pc_hold", pc, 6);
        chk("halted_ready_hold", instr_ready, 0);
        chk_reg("halted_r6_untouched", 8'd6, '0);
        instr_valid = 1'b0;
        reset = 1'b1;
        #1 chk("ready_reset3", instr_ready, 0);
        tick(); reset = 1'b0;
        #1 chk("reset3_pc", pc, 0);
        chk("reset3_halted", halted, 0);
        chk("reset3_ready", instr_ready, 1);

        // reset one cycle after acceptance drops the write
        instr = mk(4'd1, 4'd0, 8'd8, 8'd1, 8'd2); instr_valid = 1'b1;
        #1 chk("flush_ready", instr_ready, 1);
        tick(); instr_valid = 1'b0; reset = 1'b1;
        tick(); reset = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_pc", pc, 0);
        tick(); tick(); tick(); tick();
        chk_reg("flush_r8_unchanged", 8'd8, rep(16'h1234));
        chk("flush_busy_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simd_processing_block.md
# simd_processing_block

Parametrised successor to the fixed 32-lane bf16 processing block. It accepts 32-bit instructions over a valid/ready stream, reads two vector operands from an internal register file and executes them on `LANES` instances of `alu_bf16`. Results are written back with a per-lane mask. Read-after-write hazards stall issue, and a HALT instruction drains the pipeline. The block sits between the instruction sequencer and the shared vector register file.

## Interface
- `LANES`, 32, number of bf16 lanes (1..64)
- `BITS`, 16, lane width
- `ADDR_W`, 8, register address width (2^ADDR_W vector registers)
- `PC_W`, 16, program counter width
- `ALU_LAT`, 1, `alu_bf16` pipeline latency in cycles (>=1)

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `instr_valid`  in  1  instruction offered
- `instr_ready`  out  1  instruction accepted when valid&&ready
- `instr`  in  32  [31:28] opcode, [27:24] alu_ctrl, [23:16] dst, [15:8] src1, [7:0] src2 (upper address bits zero when ADDR_W<8)
- `pc`  out  PC_W  count of accepted instructions, mod 2^PC_W
- `busy`  out  1  any instruction in issue/EX/WB
- `halted`  out  1  HALT retired
- `dbg_we`  in  1  debug register write
- `dbg_addr`  in  ADDR_W  debug address
- `dbg_wdata`  in  LANES*BITS  debug write data
- `dbg_rdata`  out  LANES*BITS  combinational read of `dbg_addr`

## Operation
- Opcodes:
  - 0 NOP.
  - 1 ALU: dst[i] = alu(src1[i], src2[i], alu_ctrl) for lanes with mask[i]=1.
  - 2 HALT.
  - 3 SETMASK: mask[i] = (src1 lane i != 0).
  - 4..15 behave as NOP.
- State machine RUN -> DRAIN -> HALTED:
  - RUN: ready = instr_valid-independent of halt; computed as !hazard.
  - Accepting HALT moves to DRAIN. `instr_ready` is 0 from the next cycle.
  - DRAIN -> HALTED when busy=0. HALTED holds until `reset`.
- Hazard:
  - A hazard exists when the ALU/SETMASK source src1, or the ALU source src2, equals the dst of a valid ALU in issue, any EX stage, or WB.
  - `instr_ready` = (state==RUN) && !hazard. This path is combinational from `instr`; the producer holds `instr` stable while valid.
  - No forwarding.
- Mask:
  - Sampled when an instruction occupies the issue stage.
  - SETMASK updates the mask at the end of its issue cycle, so the next accepted instruction sees it.
  - An all-zero mask makes ALU a no-op on registers.
- Writeback:
  - Per-lane enable = captured mask.
  - If `dbg_we` targets the same address in the same cycle, WB data wins on enabled lanes and debug data wins on the others.
- `pc` wraps from 2^PC_W-1 to 0.
- Reset:
  - Outputs: pc=0, busy=0, halted=0, state=RUN, mask=all ones.
  - All in-flight instructions are discarded and their writes dropped.
  - Register file contents are not cleared.
  - `instr_ready` is 0 during the reset cycle.

## Timing
- Instruction accepted in cycle T is registered into issue; it reads the register file in T+1.
- The ALU result is written at the rising edge ending cycle T+1+ALU_LAT. It is visible on `dbg_rdata` in T+2+ALU_LAT.
- A dependent instruction is accepted no earlier than T+2+ALU_LAT.
- Throughput is 1 instruction/cycle without hazards. `pc` updates at the edge after acceptance.
- `busy` is registered and is high in the cycles an instruction occupies issue/EX/WB.
- `halted` asserts the cycle after busy falls in DRAIN.

## Structure
- Package `simd_pkg`:
  - opcode enum (NOP, ALU, HALT, SETMASK)
  - instruction field slice constants
  - state enum (RUN, DRAIN, HALTED)
- Sub-module `lane_reg_file`:
  - 2^ADDR_W × LANES*BITS
  - three async read ports (src1, src2, dbg) and one write port with LANES-bit lane enable plus debug write merge
- `alu_bf16` instantiated in a generate loop; valid/dst/mask shift register of depth ALU_LAT alongside.

## Test plan
- Debug-load r1=0x3F80 (1.0), r2=0x4000 (2.0) all lanes; ALU add (alu_ctrl 0) dst=3 at T -> r3 reads 0x4040 in every lane at T+2+ALU_LAT; pc=1.
- Back-to-back r3=r1+r2 then r4=r3+r1 -> second held with instr_ready=0 until T+2+ALU_LAT, then accepted; r4=0x4080.
- SETMASK from register with only lanes 0 and 5 nonzero, then ALU into r7 pre-loaded 0x0000 -> only lanes 0 and 5 change; mask reset restores all lanes.
- 2^PC_W+3 NOPs streamed with valid held high -> pc=3, no stalls, busy low two cycles after last.
- ALU then HALT then ALU offered -> first ALU writes back, halted rises after busy=0, third never accepted; reset -> pc=0, halted=0, ready=1 next cycle.
- Reset asserted one cycle after ALU acceptance -> destination register unchanged, busy=0 after reset.
